// File: rtl/boot_loader.sv
// Boot sequencer: receives a length-prefixed, checksummed byte image and writes it into
// instruction memory as little-endian words, holding the core in reset until the image verifies.
module boot_loader #(
  parameter int ADDR_BITS = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        mem_w_enb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_w_data,
  output logic        core_rst,
  output logic        busy,
  output logic        done,
  output logic        error
);

  localparam logic [32:0] WORD_LIMIT = 33'd1 << ADDR_BITS;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    DATA,
    WRITE,
    CSUM,
    DONE,
    ERROR
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] count;
  logic [23:0] word;
  logic [1:0]  lane;
  logic [7:0]  acc;
  logic        accept;
  logic        last_byte;
  logic [31:0] hdr_n;
  logic        hdr_bad;

  assign accept    = rx_valid & rx_ready;
  assign last_byte = (lane == 2'd3);
  // The header shifts in from the top, so the fourth byte completes it with the first byte at [7:0].
  assign hdr_n     = {rx_data, count[31:8]};
  assign hdr_bad   = (hdr_n == 32'd0) || ({1'b0, hdr_n} > WORD_LIMIT);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE, ERROR: begin
        if (start) state_nxt = HDR;
      end
      HDR: begin
        if (accept && last_byte) state_nxt = hdr_bad ? ERROR : DATA;
      end
      DATA: begin
        if (accept && last_byte) state_nxt = WRITE;
      end
      WRITE: begin
        state_nxt = (count == 32'd1) ? CSUM : DATA;
      end
      CSUM: begin
        if (accept) state_nxt = (rx_data == acc) ? DONE : ERROR;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      rx_ready   <= 1'b0;
      mem_w_enb  <= 1'b0;
      mem_addr   <= 32'd0;
      mem_w_data <= 32'd0;
      core_rst   <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      count      <= 32'd0;
      word       <= 24'd0;
      lane       <= 2'd0;
      acc        <= 8'd0;
    end else begin
      state     <= state_nxt;
      rx_ready  <= (state_nxt == HDR) || (state_nxt == DATA) || (state_nxt == CSUM);
      mem_w_enb <= (state_nxt == WRITE);
      busy      <= (state_nxt == HDR) || (state_nxt == DATA) ||
                   (state_nxt == WRITE) || (state_nxt == CSUM);
      done      <= (state_nxt == DONE);
      error     <= (state_nxt == ERROR);
      core_rst  <= (state_nxt != DONE);

      case (state)
        IDLE, DONE, ERROR: begin
          if (start) begin
            count    <= 32'd0;
            lane     <= 2'd0;
            acc      <= 8'd0;
            mem_addr <= 32'd0;
          end
        end
        HDR: begin
          if (accept) begin
            count <= hdr_n;
            lane  <= lane + 2'd1;
          end
        end
        DATA: begin
          if (accept) begin
            acc  <= acc + rx_data;
            lane <= lane + 2'd1;
            case (lane)
              2'd0:    word[7:0]   <= rx_data;
              2'd1:    word[15:8]  <= rx_data;
              2'd2:    word[23:16] <= rx_data;
              default: mem_w_data  <= {rx_data, word};
            endcase
          end
        end
        WRITE: begin
          mem_addr <= mem_addr + 32'd4;
          count    <= count - 32'd1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_boot_loader.sv
// Bench for boot_loader: directed and random images on a full-size and a tiny (ADDR_BITS=2)
// instance, checked against a stream-level model of the expected writes and final outcome.
module tb_boot_loader;

  typedef struct {
    int          d;
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst_s   [2];
  logic        start_s [2];
  logic        rxv     [2];
  logic [7:0]  rxd     [2];
  logic        rdy     [2];
  logic        wen     [2];
  logic [31:0] maddr   [2];
  logic [31:0] mdata   [2];
  logic        crst    [2];
  logic        bsy     [2];
  logic        dn      [2];
  logic        er      [2];

  int          errors = 0;
  int          checks = 0;
  int          ready_viol = 0;
  wr_t         wq[$];
  logic [7:0]  img[$];
  logic [31:0] exp_addr[$];
  logic [31:0] exp_data[$];
  logic        exp_done;
  int          consumed;

  always #5 clk = ~clk;

  boot_loader #(.ADDR_BITS(10)) dut (
    .clk(clk), .rst(rst_s[0]), .start(start_s[0]), .rx_valid(rxv[0]), .rx_data(rxd[0]),
    .rx_ready(rdy[0]), .mem_w_enb(wen[0]), .mem_addr(maddr[0]), .mem_w_data(mdata[0]),
    .core_rst(crst[0]), .busy(bsy[0]), .done(dn[0]), .error(er[0])
  );

  boot_loader #(.ADDR_BITS(2)) dut_small (
    .clk(clk), .rst(rst_s[1]), .start(start_s[1]), .rx_valid(rxv[1]), .rx_data(rxd[1]),
    .rx_ready(rdy[1]), .mem_w_enb(wen[1]), .mem_addr(maddr[1]), .mem_w_data(mdata[1]),
    .core_rst(crst[1]), .busy(bsy[1]), .done(dn[1]), .error(er[1])
  );

  // Every cycle with a write enable is logged; a byte must never be offered as accepted then.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (wen[d] === 1'b1) begin
        wr_t w;
        w.d    = d;
        w.addr = maddr[d];
        w.data = mdata[d];
        wq.push_back(w);
        if (rdy[d] !== 1'b0) ready_viol++;
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic pulseStart(input int d);
    start_s[d] = 1'b1;
    @(posedge clk); #1;
    start_s[d] = 1'b0;
  endtask

  task automatic pulseReset(input int d);
    rst_s[d] = 1'b1;
    rxv[d]   = 1'b0;
    @(posedge clk); #1;
    rst_s[d] = 1'b0;
  endtask

  // Offers img[first..last-1] one byte at a time; gapped mode drops rx_valid at random.
  task automatic applyStimulus(input int d, input int first, input int last, input bit gapped);
    for (int i = first; i < last; i++) begin
      bit accepted = 1'b0;
      if (gapped) begin
        repeat ($urandom_range(0, 2)) begin
          rxv[d] = 1'b0;
          @(posedge clk); #1;
        end
      end
      rxv[d] = 1'b1;
      rxd[d] = img[i];
      for (int c = 0; c < 40 && !accepted; c++) begin
        @(negedge clk);
        if (rdy[d] === 1'b1 && rxv[d] === 1'b1) accepted = 1'b1;
        @(posedge clk); #1;
        if (gapped && !accepted) rxv[d] = 1'($urandom_range(0, 1));
      end
      rxv[d] = 1'b0;
      checkOutput("byte_accepted", {31'd0, accepted}, 32'd1);
    end
  endtask

  task automatic makeImage(input int n, input bit bad);
    logic [7:0] sum = 8'd0;
    logic [31:0] nn = n;
    img.delete();
    for (int b = 0; b < 4; b++) img.push_back(nn[8*b +: 8]);
    if (n >= 1 && n <= 64) begin
      for (int w = 0; w < n; w++) begin
        logic [31:0] word = $urandom;
        for (int b = 0; b < 4; b++) begin
          img.push_back(word[8*b +: 8]);
          sum = sum + word[8*b +: 8];
        end
      end
      img.push_back(bad ? sum + 8'd1 : sum);
    end
  endtask

  // Stream-level model: parse header, list the words and their addresses, verify checksum.
  task automatic buildExpected(input int abits);
    longint n;
    longint limit = 64'd1 << abits;
    logic [7:0] sum = 8'd0;
    exp_addr.delete();
    exp_data.delete();
    n = {img[3], img[2], img[1], img[0]};
    if (n == 0 || n > limit) begin
      exp_done = 1'b0;
      consumed = 4;
      return;
    end
    for (int w = 0; w < n; w++) begin
      exp_addr.push_back(32'(4 * w));
      exp_data.push_back({img[4+4*w+3], img[4+4*w+2], img[4+4*w+1], img[4+4*w]});
      for (int b = 0; b < 4; b++) sum = sum + img[4 + 4*w + b];
    end
    exp_done = (img[4 + 4*n] == sum);
    consumed = 4 + 4 * int'(n) + 1;
  endtask

  task automatic checkRun(input int d, input string tag);
    checkOutput({tag, "_nwrites"}, wq.size(), exp_addr.size());
    for (int i = 0; i < wq.size() && i < exp_addr.size(); i++) begin
      checkOutput({tag, "_wr_dut"}, wq[i].d, d);
      checkOutput({tag, "_wr_addr"}, wq[i].addr, exp_addr[i]);
      checkOutput({tag, "_wr_data"}, wq[i].data, exp_data[i]);
    end
    checkOutput({tag, "_done"}, dn[d], exp_done);
    checkOutput({tag, "_error"}, er[d], !exp_done);
    checkOutput({tag, "_core_rst"}, crst[d], !exp_done);
    checkOutput({tag, "_busy"}, bsy[d], 1'b0);
    checkOutput({tag, "_ready_in_write"}, ready_viol, 0);
  endtask

  task automatic runImage(input int d, input int abits, input bit gapped, input string tag);
    buildExpected(abits);
    wq.delete();
    pulseStart(d);
    applyStimulus(d, 0, consumed, gapped);
    checkRun(d, tag);
  endtask

  task automatic checkResetValues(input int d, input string tag);
    checkOutput({tag, "_core_rst"}, crst[d], 1'b1);
    checkOutput({tag, "_rx_ready"}, rdy[d], 1'b0);
    checkOutput({tag, "_w_enb"}, wen[d], 1'b0);
    checkOutput({tag, "_busy"}, bsy[d], 1'b0);
    checkOutput({tag, "_done"}, dn[d], 1'b0);
    checkOutput({tag, "_error"}, er[d], 1'b0);
    checkOutput({tag, "_addr"}, maddr[d], 32'd0);
    checkOutput({tag, "_wdata"}, mdata[d], 32'd0);
  endtask

  task automatic loadGood();
    img = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
            8'h93, 8'h00, 8'hA0, 8'h00, 8'h46};
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst_s[d] = 1'b1; start_s[d] = 1'b0; rxv[d] = 1'b0; rxd[d] = 8'd0;
    end
    repeat (3) @(posedge clk);
    #1;
    rst_s[0] = 1'b0;
    rst_s[1] = 1'b0;
    checkResetValues(0, "reset0");
    checkResetValues(1, "reset1");

    $display("[TB] good image");
    loadGood();
    runImage(0, 10, 1'b0, "good");
    checkOutput("good_w0_addr", wq.size() > 0 ? wq[0].addr : 32'hFFFF_FFFF, 32'h0);
    checkOutput("good_w0_data", wq.size() > 0 ? wq[0].data : 32'hFFFF_FFFF, 32'h0000_0013);
    checkOutput("good_w1_addr", wq.size() > 1 ? wq[1].addr : 32'hFFFF_FFFF, 32'h4);
    checkOutput("good_w1_data", wq.size() > 1 ? wq[1].data : 32'hFFFF_FFFF, 32'h00A0_0093);
    checkOutput("good_done_lit", dn[0], 1'b1);

    $display("[TB] bad checksum");
    loadGood();
    img[12] = 8'h47;
    runImage(0, 10, 1'b0, "badsum");
    checkOutput("badsum_error_lit", er[0], 1'b1);

    $display("[TB] zero header");
    makeImage(0, 1'b0);
    runImage(0, 10, 1'b0, "zero");
    rxv[0] = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    rxv[0] = 1'b0;
    checkOutput("zero_no_writes", wq.size(), 0);
    checkOutput("zero_still_error", er[0], 1'b1);

    $display("[TB] word-count limit");
    makeImage(4, 1'b0);
    runImage(1, 2, 1'b0, "lim4");
    checkOutput("lim4_last_addr", wq.size() == 4 ? wq[3].addr : 32'hFFFF_FFFF, 32'hC);
    makeImage(5, 1'b0);
    runImage(1, 2, 1'b0, "lim5");
    checkOutput("lim5_error_lit", er[1], 1'b1);

    $display("[TB] gapped stream");
    loadGood();
    runImage(0, 10, 1'b1, "gapped");

    $display("[TB] reset mid-load");
    loadGood();
    wq.delete();
    pulseStart(0);
    applyStimulus(0, 0, 10, 1'b0);
    pulseReset(0);
    checkResetValues(0, "midrst");
    rxv[0] = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    rxv[0] = 1'b0;
    checkOutput("midrst_writes", wq.size(), 1);
    runImage(0, 10, 1'b0, "after_rst");

    $display("[TB] start while busy");
    loadGood();
    buildExpected(10);
    wq.delete();
    pulseStart(0);
    applyStimulus(0, 0, 6, 1'b0);
    pulseStart(0);
    applyStimulus(0, 6, consumed, 1'b0);
    checkRun(0, "busy_start");

    $display("[TB] random images");
    for (int k = 0; k < 8; k++) begin
      int d = $urandom_range(0, 1);
      int n = (d == 1) ? $urandom_range(0, 6) : $urandom_range(1, 8);
      makeImage(n, $urandom_range(0, 3) == 0);
      runImage(d, (d == 1) ? 2 : 10, 1'($urandom_range(0, 1)), "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
